// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage controls of the pipeline sequencer.
// Counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd_addr;
  logic       ex_rd_valid;
  logic       ex_is_load;
  logic       ex_jump_signal;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_ack;
  logic       pc_en;
  logic       pc_sel_jump;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic [1:0] ctrl_state;
  logic       mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_rd_addr, ex_rd_valid, ex_is_load, ex_jump_signal,
    output imem_ready, dmem_req, dmem_ack,
    input  pc_en, pc_sel_jump, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    input  ex_mem_en, mem_wb_en, ctrl_state, mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_rd_addr, ex_rd_valid, ex_is_load, ex_jump_signal,
    input  imem_ready, dmem_req, dmem_ack,
    output pc_en, pc_sel_jump, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    output ex_mem_en, mem_wb_en, ctrl_state, mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage core.
// Optional stall/flush counters under PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int STARTUP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // Control vector order: pc_en, pc_sel_jump, if_id_en, if_id_flush,
  // id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en.
  localparam logic [7:0] C_BUBBLE     = 8'b0001_0111;
  localparam logic [7:0] C_JUMP       = 8'b1101_0111;
  localparam logic [7:0] C_LOAD_USE   = 8'b0000_0111;
  localparam logic [7:0] C_FETCH_WAIT = 8'b0001_1011;
  localparam logic [7:0] C_RUN        = 8'b1010_1011;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  logic [7:0]       ctl;
  logic             advance;
  logic             waiting;
  logic             load_use;

  assign load_use = bus.ex_is_load & bus.ex_rd_valid & (bus.ex_rd_addr != 5'd0) &
                    ((bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                     (bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd_addr)));

  always_comb begin
    next_state = state;
    ctl        = 8'b0;
    advance    = 1'b0;
    waiting    = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.dmem_req && !bus.dmem_ack) next_state = ST_MEM_WAIT;
        else                               advance    = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ack) begin
          waiting = 1'b1;
        end else begin
          advance    = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_STARTUP: begin
        ctl = C_BUBBLE;
        if (cnt == START_LAST) next_state = ST_RUN;
      end
      default: begin
        ctl        = C_BUBBLE;
        next_state = ST_STARTUP;
      end
    endcase
    // A jump squashes the younger instructions, so it outranks a pending load-use stall.
    if (advance) begin
      if (bus.ex_jump_signal)  ctl = C_JUMP;
      else if (load_use)       ctl = C_LOAD_USE;
      else if (!bus.imem_ready) ctl = C_FETCH_WAIT;
      else                     ctl = C_RUN;
    end
    if (rst) ctl = 8'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_STARTUP;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_STARTUP && next_state == ST_STARTUP) begin
        cnt <= cnt + 1'b1;
      end else if (waiting) begin
        if (cnt != '1)       cnt       <= cnt + 1'b1;
        if (cnt >= TO_LAST)  timeout_q <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign {bus.pc_en, bus.pc_sel_jump, bus.if_id_en, bus.if_id_flush,
          bus.id_ex_en, bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en} = ctl;
  assign bus.ctrl_state  = state;
  assign bus.mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if ((state == ST_RUN || state == ST_MEM_WAIT) && !ctl[7]) stall_q <= stall_q + 32'd1;
      if (advance && bus.ex_jump_signal)                         flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`endif

endmodule
